game_door_ctrl: RTL
===================

GAME_DOOR_CTRL -- requirements
Module: game_door_ctrl

Interface
REQ-001 Parameter OPEN_FRAMES, default 16, frames spent in OPENING (legal 1..255).
REQ-002 Parameter HOLD_FRAMES, default 180, frames door stays OPEN with zone clear before closing (legal 1..255).
REQ-003 Parameter CLOSE_FRAMES, default 16, frames spent in CLOSING (legal 1..255).
REQ-004 clk  in  1  pixel clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 vsync  in  1  vsync from VGA timing chain; its rising edge is the frame tick.
REQ-007 key_in  in  1  player holds the door key.
REQ-008 player_at_door  in  1  player sprite overlaps the door zone.
REQ-009 door_out  out  1  1 = door open; drives door_in of the wall-drawing stage (wall hidden).
REQ-010 door_state  out  2  00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING.
REQ-011 door_evt  out  1  one-cycle pulse on entry to OPEN.

Function
REQ-012 Frame tick SHALL be vsync high while registered previous vsync is low; exactly one tick per vsync rising edge.
REQ-013 FSM states SHALL be CLOSED, OPENING, OPEN, CLOSING with 8-bit frame counter cnt.
REQ-014 CLOSED: key_in && player_at_door sampled high -> OPENING next cycle, cnt=0; a tick in that same cycle is not counted.
REQ-015 OPENING: cnt +1 per tick; tick with cnt==OPEN_FRAMES-1 -> OPEN, cnt=0.
REQ-016 OPEN: player_at_door high -> cnt forced 0; else cnt +1 per tick; tick with cnt==HOLD_FRAMES-1 and player_at_door low -> CLOSING, cnt=0.
REQ-017 CLOSING: player_at_door high -> OPEN, cnt=0 (key not required); else cnt +1 per tick; tick with cnt==CLOSE_FRAMES-1 -> CLOSED, cnt=0.
REQ-018 player_at_door wins over counter expiry in the same cycle in OPEN and CLOSING.
REQ-019 door_out, door_state, door_evt SHALL be registered from next-state: door_out=1 iff state==OPEN, visible in the same cycle door_state shows OPEN.
REQ-020 door_evt SHALL be 1 exactly one cycle, in the cycle door_state first shows OPEN (from OPENING or CLOSING).
REQ-021 cnt SHALL never exceed the active state's limit-1; no wrap-around reachable.
REQ-022 Inputs other than vsync SHALL be used unsynchronised (same clock domain).

Reset
REQ-023 rst low at a clock edge SHALL set state CLOSED, cnt 0, vsync_prev 0, door_out 0, door_state 00, door_evt 0, from any state.
REQ-024 First cycle after rst rises SHALL not generate a tick unless vsync rises after reset.

Configuration
REQ-025 Macro GAME_DOOR_AUTOCLOSE_EN defined: OPEN times out to CLOSING per REQ-016.
REQ-026 Macro undefined: OPEN SHALL be terminal until reset, cnt held 0, CLOSING unreachable; all other behaviour unchanged.

Verification (OPEN_FRAMES=2, HOLD_FRAMES=3, CLOSE_FRAMES=2, macro defined)
REQ-027 Reset: rst=0 mid-OPEN -> next cycle door_state=00, door_out=0, door_evt=0.
REQ-028 Open: key_in=1, player_at_door=1 one cycle in CLOSED -> door_state=01; after 2 vsync rises door_state=10, door_out=1, door_evt high 1 cycle.
REQ-029 No key: player_at_door=1, key_in=0 for 10 frames -> door_state stays 00, door_out=0.
REQ-030 Hold: in OPEN, player_at_door=1 for 5 frames then 0 -> CLOSING only on 3rd tick after release; door_out=0 same cycle.
REQ-031 Reopen: in CLOSING after 1 tick, player_at_door=1 -> next cycle door_state=10, door_out=1, door_evt=1.
REQ-032 Macro undefined: reach OPEN, 300 frames, player_at_door=0 -> door_state stays 10, door_out=1.

Source files
------------

// File: rtl/game_door_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_door_ctrl
//  Description : Frame-paced door controller for the game wall stage. The
//                door opens when a key-holding player stands at it, stays open
//                while the zone is occupied and, when GAME_DOOR_AUTOCLOSE_EN
//                is defined, closes again after a hold time.
//                Optional feature macro: GAME_DOOR_AUTOCLOSE_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module game_door_ctrl #(
    parameter int unsigned OPEN_FRAMES  = 16,
    parameter int unsigned HOLD_FRAMES  = 180,
    parameter int unsigned CLOSE_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       key_in,
    input  logic       player_at_door,
    output logic       door_out,
    output logic [1:0] door_state,
    output logic       door_evt
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'b00,
        ST_OPENING = 2'b01,
        ST_OPEN    = 2'b10,
        ST_CLOSING = 2'b11
    } state_t;

    // Last counter value of each timed state (limit - 1)
    localparam logic [7:0] c_open_last  = 8'(OPEN_FRAMES - 1);
    localparam logic [7:0] c_hold_last  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] c_close_last = 8'(CLOSE_FRAMES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_cnt;
    logic [7:0] w_next_cnt;
    logic [7:0] w_last;
    logic       w_at_last;
    logic       r_vsync_prev;
    logic       w_tick;
    logic       r_door_out;
    logic [1:0] r_door_state;
    logic       r_door_evt;

    // One tick per vsync rising edge
    assign w_tick    = vsync & ~r_vsync_prev;
    assign w_at_last = (r_cnt == w_last);

    assign door_out   = r_door_out;
    assign door_state = r_door_state;
    assign door_evt   = r_door_evt;

    // Select the expiry value for the state currently being timed
    always_comb begin
        w_last = 8'd0;
        case (r_state)
            ST_OPENING: w_last = c_open_last;
            ST_OPEN:    w_last = c_hold_last;
            ST_CLOSING: w_last = c_close_last;
            default:    w_last = 8'd0;
        endcase
    end

    // Next-state and frame-counter logic; player presence beats expiry
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_CLOSED: begin
                w_next_cnt = 8'd0;
                if (key_in && player_at_door) begin
                    w_next_state = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (w_tick) begin
                    if (w_at_last) begin
                        w_next_state = ST_OPEN;
                        w_next_cnt   = 8'd0;
                    end else begin
                        w_next_cnt = r_cnt + 8'd1;
                    end
                end
            end
            ST_OPEN: begin
`ifdef GAME_DOOR_AUTOCLOSE_EN
                if (player_at_door) begin
                    w_next_cnt = 8'd0;
                end else if (w_tick) begin
                    if (w_at_last) begin
                        w_next_state = ST_CLOSING;
                        w_next_cnt   = 8'd0;
                    end else begin
                        w_next_cnt = r_cnt + 8'd1;
                    end
                end
`else
                // Without auto-close the open door is terminal until reset
                w_next_cnt = 8'd0;
`endif
            end
            ST_CLOSING: begin
                if (player_at_door) begin
                    w_next_state = ST_OPEN;
                    w_next_cnt   = 8'd0;
                end else if (w_tick) begin
                    if (w_at_last) begin
                        w_next_state = ST_CLOSED;
                        w_next_cnt   = 8'd0;
                    end else begin
                        w_next_cnt = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_next_state = ST_CLOSED;
                w_next_cnt   = 8'd0;
            end
        endcase
    end

    // State, counter, edge detector and outputs registered from next-state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_CLOSED;
            r_cnt        <= 8'd0;
            r_vsync_prev <= 1'b0;
            r_door_out   <= 1'b0;
            r_door_state <= 2'b00;
            r_door_evt   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_vsync_prev <= vsync;
            r_door_out   <= (w_next_state == ST_OPEN);
            r_door_state <= w_next_state;
            r_door_evt   <= (w_next_state == ST_OPEN) && (r_state != ST_OPEN);
        end
    end

endmodule
`default_nettype wire
